// File: rtl/tbeb_if.sv
// ============================================================================
// Module      : tbeb_if
// Description : Code-group in / decoded-byte out bundle for the 10b/8b decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tbeb_if;
    logic [9:0] tb;
    logic       tb_valid;
    logic [7:0] eb;
    logic       k;
    logic       eb_valid;
    logic       code_err;
    logic       disp_err;
    logic       rd;
    logic       sync;

    modport master (
        output tb, tb_valid,
        input  eb, k, eb_valid, code_err, disp_err, rd, sync
    );

    modport slave (
        input  tb, tb_valid,
        output eb, k, eb_valid, code_err, disp_err, rd, sync
    );
endinterface

`default_nettype wire

// File: rtl/tbeb.sv
// ============================================================================
// Module      : tbeb
// Description : 10b/8b decoder with running-disparity check and comma-based
//               word-sync FSM (FSM present only when TBEB_SYNC_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbeb #(
    parameter int SYNC_ACQ  = 3,
    parameter int SYNC_LOSS = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    tbeb_if.slave     bus
);

    logic [5:0] w_c6;
    logic [3:0] w_c4;
    logic [3:0] w_c4_eff;
    logic [4:0] w_v6;
    logic       w_ok6;
    logic [2:0] w_v4;
    logic       w_ok4;
    logic       w_k28;
    logic       w_kx;
    logic       w_code_err;
    logic       w_disp_err;
    logic       w_k;
    logic [7:0] w_eb;
    logic [3:0] w_ones;
    logic       w_rd_next;

    logic [7:0] r_eb;
    logic       r_k;
    logic       r_eb_valid;
    logic       r_code_err;
    logic       r_disp_err;
    logic       r_rd;

    assign w_c6  = bus.tb[9:4];
    assign w_c4  = bus.tb[3:0];
    assign w_k28 = (w_c6 == 6'b001111) || (w_c6 == 6'b110000);
    // K.28 in rd+ carries the complement of the 4b code used in rd-.
    assign w_c4_eff = (w_c6 == 6'b110000) ? ~w_c4 : w_c4;

    always_comb begin
        w_ok6 = 1'b1;
        w_v6  = 5'd0;
        case (w_c6)
            6'b100111, 6'b011000: w_v6 = 5'd0;
            6'b011101, 6'b100010: w_v6 = 5'd1;
            6'b101101, 6'b010010: w_v6 = 5'd2;
            6'b110001:            w_v6 = 5'd3;
            6'b110101, 6'b001010: w_v6 = 5'd4;
            6'b101001:            w_v6 = 5'd5;
            6'b011001:            w_v6 = 5'd6;
            6'b111000, 6'b000111: w_v6 = 5'd7;
            6'b111001, 6'b000110: w_v6 = 5'd8;
            6'b100101:            w_v6 = 5'd9;
            6'b010101:            w_v6 = 5'd10;
            6'b110100:            w_v6 = 5'd11;
            6'b001101:            w_v6 = 5'd12;
            6'b101100:            w_v6 = 5'd13;
            6'b011100:            w_v6 = 5'd14;
            6'b010111, 6'b101000: w_v6 = 5'd15;
            6'b011011, 6'b100100: w_v6 = 5'd16;
            6'b100011:            w_v6 = 5'd17;
            6'b010011:            w_v6 = 5'd18;
            6'b110010:            w_v6 = 5'd19;
            6'b001011:            w_v6 = 5'd20;
            6'b101010:            w_v6 = 5'd21;
            6'b011010:            w_v6 = 5'd22;
            6'b111010, 6'b000101: w_v6 = 5'd23;
            6'b110011, 6'b001100: w_v6 = 5'd24;
            6'b100110:            w_v6 = 5'd25;
            6'b010110:            w_v6 = 5'd26;
            6'b110110, 6'b001001: w_v6 = 5'd27;
            6'b001110:            w_v6 = 5'd28;
            6'b101110, 6'b010001: w_v6 = 5'd29;
            6'b011110, 6'b100001: w_v6 = 5'd30;
            6'b101011, 6'b010100: w_v6 = 5'd31;
            6'b001111, 6'b110000: w_v6 = 5'd28;
            default:              w_ok6 = 1'b0;
        endcase
    end

    always_comb begin
        w_ok4 = 1'b1;
        w_v4  = 3'd0;
        case (w_c4_eff)
            4'b1011, 4'b0100:                   w_v4 = 3'd0;
            4'b1001:                            w_v4 = 3'd1;
            4'b0101:                            w_v4 = 3'd2;
            4'b1100, 4'b0011:                   w_v4 = 3'd3;
            4'b1101, 4'b0010:                   w_v4 = 3'd4;
            4'b1010:                            w_v4 = 3'd5;
            4'b0110:                            w_v4 = 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: w_v4 = 3'd7;
            default:                            w_ok4 = 1'b0;
        endcase
    end

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'd0, bus.tb[i]};
        end
    end

    assign w_kx = w_ok6 && ((w_v6 == 5'd23) || (w_v6 == 5'd27) ||
                            (w_v6 == 5'd29) || (w_v6 == 5'd30)) &&
                  ((w_c4 == 4'b1000) || (w_c4 == 4'b0111));

    assign w_code_err = !(w_ok6 && w_ok4);
    assign w_k        = !w_code_err && (w_k28 || w_kx);
    assign w_eb       = w_code_err ? 8'h00 : {w_v4, w_v6};

    assign w_disp_err = (w_ones < 4'd4) || (w_ones > 4'd6) ||
                        ((w_ones == 4'd6) &&  r_rd) ||
                        ((w_ones == 4'd4) && !r_rd);

    assign w_rd_next = (w_ones > 4'd5) ? 1'b1 :
                       (w_ones < 4'd5) ? 1'b0 : r_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_eb       <= 8'h00;
            r_k        <= 1'b0;
            r_eb_valid <= 1'b0;
            r_code_err <= 1'b0;
            r_disp_err <= 1'b0;
            r_rd       <= 1'b0;
        end else begin
            r_eb_valid <= bus.tb_valid;
            if (bus.tb_valid) begin
                r_eb       <= w_eb;
                r_k        <= w_k;
                r_code_err <= w_code_err;
                r_disp_err <= w_disp_err;
                r_rd       <= w_rd_next;
            end
        end
    end

`ifdef TBEB_SYNC_EN
    localparam int c_acq_w  = (SYNC_ACQ  < 2) ? 1 : $clog2(SYNC_ACQ + 1);
    localparam int c_loss_w = (SYNC_LOSS < 2) ? 1 : $clog2(SYNC_LOSS + 1);
    localparam logic [c_acq_w-1:0]  c_acq_last  = c_acq_w'(SYNC_ACQ - 1);
    localparam logic [c_loss_w-1:0] c_loss_last = c_loss_w'(SYNC_LOSS - 1);

    typedef enum logic [0:0] {
        UNSYNC = 1'b0,
        SYNC   = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_acq_w-1:0]  r_acq_cnt;
    logic [c_loss_w-1:0] r_err_cnt;
    logic                r_sync;
    logic                w_err;
    logic                w_comma;

    assign w_err   = w_code_err || w_disp_err;
    assign w_comma = w_k28 && !w_code_err &&
                     ((w_v4 == 3'd1) || (w_v4 == 3'd5) || (w_v4 == 3'd7));

    // Transition fires on the word that brings a counter to its threshold, so
    // counters never step past threshold-1 and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= UNSYNC;
            r_acq_cnt <= '0;
            r_err_cnt <= '0;
            r_sync    <= 1'b0;
        end else if (bus.tb_valid) begin
            case (r_state)
                UNSYNC: begin
                    if (w_err) begin
                        r_acq_cnt <= '0;
                    end else if (w_comma) begin
                        if (r_acq_cnt >= c_acq_last) begin
                            r_state   <= SYNC;
                            r_sync    <= 1'b1;
                            r_acq_cnt <= '0;
                            r_err_cnt <= '0;
                        end else begin
                            r_acq_cnt <= r_acq_cnt + 1'b1;
                        end
                    end
                end
                SYNC: begin
                    if (w_err) begin
                        if (r_err_cnt >= c_loss_last) begin
                            r_state   <= UNSYNC;
                            r_sync    <= 1'b0;
                            r_acq_cnt <= '0;
                            r_err_cnt <= '0;
                        end else begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                    end else begin
                        r_err_cnt <= '0;
                    end
                end
                default: begin
                    r_state   <= UNSYNC;
                    r_sync    <= 1'b0;
                    r_acq_cnt <= '0;
                    r_err_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.sync = r_sync;
`else
    assign bus.sync = reset_n;
`endif

    assign bus.eb       = r_eb;
    assign bus.k        = r_k;
    assign bus.eb_valid = r_eb_valid;
    assign bus.code_err = r_code_err;
    assign bus.disp_err = r_disp_err;
    assign bus.rd       = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_tbeb.sv
// ============================================================================
// Module      : tb_tbeb
// Description : Directed self-checking bench for the tbeb 10b/8b decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tbeb;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    tbeb_if bus ();

    tbeb #(
        .SYNC_ACQ  (3),
        .SYNC_LOSS (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic apply(input logic [9:0] w);
        bus.tb       = w;
        bus.tb_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus.tb_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.tb_valid = 1'b0;
        reset_n      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic expect_word(input string name, input logic [7:0] eb,
                               input logic k, input logic ce, input logic de,
                               input logic rd);
        total++;
        if ({bus.eb_valid, bus.eb, bus.k, bus.code_err, bus.disp_err, bus.rd} !==
            {1'b1, eb, k, ce, de, rd}) begin
            bad++;
            $display("FAIL %s: got v=%b eb=%h k=%b ce=%b de=%b rd=%b want v=1 eb=%h k=%b ce=%b de=%b rd=%b",
                     name, bus.eb_valid, bus.eb, bus.k, bus.code_err, bus.disp_err, bus.rd,
                     eb, k, ce, de, rd);
        end
    endtask

    task automatic test_reset();
        bus.tb       = 10'h0FA;
        bus.tb_valid = 1'b1;
        reset_n      = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.eb, bus.k, bus.eb_valid, bus.code_err, bus.disp_err, bus.rd, bus.sync} !== 14'd0) begin
            bad++;
            $display("FAIL reset_state: got eb=%h k=%b v=%b ce=%b de=%b rd=%b sync=%b want all 0",
                     bus.eb, bus.k, bus.eb_valid, bus.code_err, bus.disp_err, bus.rd, bus.sync);
        end
        bus.tb_valid = 1'b0;
        reset_n      = 1'b1;
        @(negedge clk);
        total++;
        if (bus.eb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_valid: got %b want 0", bus.eb_valid);
        end
    endtask

    task automatic test_data();
        do_reset();
        apply(10'h274);
        expect_word("d0_0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(10'h2AA);
        expect_word("d21_5", 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(10'h3A8);
        expect_word("k23_7", 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_k28_pair();
        do_reset();
        apply(10'h0FA);
        expect_word("k28_5_neg", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
        apply(10'h305);
        expect_word("k28_5_pos", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        total++;
        if ({bus.eb_valid, bus.eb, bus.k, bus.rd} !== {1'b0, 8'hBC, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL idle_hold: got v=%b eb=%h k=%b rd=%b want v=0 eb=bc k=1 rd=0",
                     bus.eb_valid, bus.eb, bus.k, bus.rd);
        end
    endtask

    task automatic test_disp_err();
        do_reset();
        apply(10'h0FA);
        apply(10'h0FA);
        expect_word("k28_5_twice", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
    endtask

    task automatic test_code_err();
        do_reset();
        apply(10'h000);
        expect_word("all_zero", 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        apply(10'h0FA);
        apply(10'h03E);
        expect_word("bad_6b_only", 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        idle();
    endtask

    task automatic test_sync();
        logic [9:0] seq [0:13];
        logic       exp_sync [0:13];
        seq = '{10'h0FA, 10'h305, 10'h0FA, 10'h000, 10'h000, 10'h000, 10'h000,
                10'h0FA, 10'h000, 10'h0FA, 10'h305, 10'h0FA, 10'h305, 10'h274};
`ifdef TBEB_SYNC_EN
        exp_sync = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_sync = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        do_reset();
        for (int i = 0; i < 14; i++) begin
            apply(seq[i]);
            total++;
            if (bus.sync !== exp_sync[i] || bus.eb_valid !== 1'b1) begin
                bad++;
                $display("FAIL sync_step%0d: got sync=%b v=%b want sync=%b v=1",
                         i, bus.sync, bus.eb_valid, exp_sync[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_midword();
        do_reset();
        apply(10'h0FA);
        bus.tb       = 10'h305;
        bus.tb_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.eb, bus.k, bus.eb_valid, bus.code_err, bus.disp_err, bus.rd, bus.sync} !== 14'd0) begin
            bad++;
            $display("FAIL async_reset: got eb=%h k=%b v=%b ce=%b de=%b rd=%b sync=%b want all 0",
                     bus.eb, bus.k, bus.eb_valid, bus.code_err, bus.disp_err, bus.rd, bus.sync);
        end
        bus.tb_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (bus.eb_valid !== 1'b0 || bus.eb !== 8'h00) begin
                bad++;
                $display("FAIL post_reset_idle%0d: got v=%b eb=%h want v=0 eb=00",
                         i, bus.eb_valid, bus.eb);
            end
        end
        apply(10'h274);
        expect_word("after_reset_d0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b1;
        bus.tb       = 10'h000;
        bus.tb_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_data();
        test_k28_pair();
        test_disp_err();
        test_code_err();
        test_sync();
        test_reset_midword();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
